// File: rtl/fb_pkg.sv
// Shared types and constants for the framebuffer blitter: geometry, pixel and
// address types, the captured command payload and the engine state encoding.
package fb_pkg;

  localparam int unsigned FB_W    = 240;
  localparam int unsigned FB_H    = 160;
  localparam int unsigned MAX_DIM = 64;
  localparam int unsigned DIM_W   = $clog2(MAX_DIM + 1);
  localparam int unsigned IDX_W   = $clog2(MAX_DIM * MAX_DIM + 1);
  localparam int unsigned ADDR_W  = 19;
  localparam int unsigned PIX_W   = 24;
  localparam int unsigned XY_W    = 8;
  localparam int unsigned POS_W   = XY_W + 1;

  typedef logic [PIX_W-1:0]  pixel_t;
  typedef logic [ADDR_W-1:0] addr_t;

  localparam pixel_t KEY_COLOR = 24'hFF00FF;

  typedef struct packed {
    logic             mode;
    addr_t            src_base;
    logic [XY_W-1:0]  dst_x;
    logic [XY_W-1:0]  dst_y;
    logic [DIM_W-1:0] width;
    logic [DIM_W-1:0] height;
    pixel_t           fill_color;
    logic             key_en;
  } blit_cmd_t;

  typedef enum logic [1:0] {
    IDLE,
    ISSUE,
    DRAIN
  } blit_state_t;

endpackage

// File: rtl/fb_blit_addr_gen.sv
// Stage-0 address generator: walks the rectangle row-major, producing the source
// read address and the unclipped 9-bit destination coordinates of each pixel.
module fb_blit_addr_gen
  import fb_pkg::*;
(
  input  logic              clk,
  input  logic              rst_n,
  input  logic              load,
  input  logic              step,
  input  logic              src_en,
  input  logic [ADDR_W-1:0] load_src_base,
  input  logic [XY_W-1:0]   load_dst_x,
  input  logic [XY_W-1:0]   load_dst_y,
  input  logic [ADDR_W-1:0] src_base,
  input  logic [XY_W-1:0]   dst_x,
  input  logic [XY_W-1:0]   dst_y,
  input  logic [DIM_W-1:0]  width,
  input  logic [DIM_W-1:0]  height,
  output logic [ADDR_W-1:0] src_addr,
  output logic [POS_W-1:0]  dx,
  output logic [POS_W-1:0]  dy,
  output logic              last_c
);

  logic [DIM_W-1:0] col;
  logic [DIM_W-1:0] row;
  logic [IDX_W-1:0] idx;
  logic [DIM_W-1:0] col_inc_c;
  logic [DIM_W-1:0] row_inc_c;
  logic [IDX_W-1:0] idx_inc_c;
  logic             col_end_c;
  logic             row_end_c;

  assign col_inc_c = col + DIM_W'(1);
  assign row_inc_c = row + DIM_W'(1);
  assign idx_inc_c = idx + IDX_W'(1);
  assign col_end_c = (col == width - DIM_W'(1));
  assign row_end_c = (row == height - DIM_W'(1));
  assign last_c    = col_end_c && row_end_c;

  // Source stride equals width, so row*width+col is simply the linear pixel index.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      col      <= '0;
      row      <= '0;
      idx      <= '0;
      src_addr <= '0;
      dx       <= '0;
      dy       <= '0;
    end else if (load) begin
      col <= '0;
      row <= '0;
      idx <= '0;
      dx  <= POS_W'(load_dst_x);
      dy  <= POS_W'(load_dst_y);
      if (src_en) src_addr <= load_src_base;
    end else if (step) begin
      idx <= idx_inc_c;
      if (src_en) src_addr <= src_base + ADDR_W'(idx_inc_c);
      if (col_end_c) begin
        col <= '0;
        row <= row_inc_c;
        dx  <= POS_W'(dst_x);
        dy  <= POS_W'(dst_y) + POS_W'(row_inc_c);
      end else begin
        col <= col_inc_c;
        dx  <= POS_W'(dst_x) + POS_W'(col_inc_c);
      end
    end
  end

endmodule

// File: rtl/fb_blitter.sv
// Rectangle blitter writing the 240x160 framebuffer at one pixel per cycle,
// with copy (colour-keyed) and fill modes and destination clipping.
module fb_blitter
  import fb_pkg::*;
(
  input  logic              Clk,
  input  logic              Reset_n,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic              cmd_mode,
  input  logic [18:0]       cmd_src_base,
  input  logic [7:0]        cmd_dst_x,
  input  logic [7:0]        cmd_dst_y,
  input  logic [6:0]        cmd_width,
  input  logic [6:0]        cmd_height,
  input  logic [23:0]       cmd_fill_color,
  input  logic              cmd_key_en,
  output logic [18:0]       src_addr,
  input  logic [23:0]       src_data,
  output logic [18:0]       FBwrite_address,
  output logic [23:0]       FBdata_In,
  output logic              FBwe,
  output logic              busy,
  output logic              done
);

  blit_state_t      state;
  blit_cmd_t        cmd_in_c;
  blit_cmd_t        cmd_q;
  logic             accept_c;
  logic             zero_c;
  logic             issue_c;
  logic             src_en_c;
  logic             last_c;
  logic             clip_c;
  logic             key_c;
  logic [POS_W-1:0] dx;
  logic [POS_W-1:0] dy;
  logic             v1;
  logic [POS_W-1:0] dx1;
  logic [POS_W-1:0] dy1;

  assign cmd_in_c = '{mode:       cmd_mode,
                      src_base:   cmd_src_base,
                      dst_x:      cmd_dst_x,
                      dst_y:      cmd_dst_y,
                      width:      cmd_width,
                      height:     cmd_height,
                      fill_color: cmd_fill_color,
                      key_en:     cmd_key_en};

  assign accept_c = (state == IDLE) && cmd_valid && cmd_ready;
  assign zero_c   = (cmd_width == '0) || (cmd_height == '0);
  assign issue_c  = (state == ISSUE);
  // The first address is loaded from the live inputs, later ones from the capture.
  assign src_en_c = accept_c ? !cmd_mode : !cmd_q.mode;
  assign clip_c   = (dx1 >= POS_W'(FB_W)) || (dy1 >= POS_W'(FB_H));
  assign key_c    = !cmd_q.mode && cmd_q.key_en && (src_data == KEY_COLOR);

  fb_blit_addr_gen u_addr_gen (
    .clk           (Clk),
    .rst_n         (Reset_n),
    .load          (accept_c && !zero_c),
    .step          (issue_c),
    .src_en        (src_en_c),
    .load_src_base (cmd_src_base),
    .load_dst_x    (cmd_dst_x),
    .load_dst_y    (cmd_dst_y),
    .src_base      (cmd_q.src_base),
    .dst_x         (cmd_q.dst_x),
    .dst_y         (cmd_q.dst_y),
    .width         (cmd_q.width),
    .height        (cmd_q.height),
    .src_addr      (src_addr),
    .dx            (dx),
    .dy            (dy),
    .last_c        (last_c)
  );

  // Command FSM; the done cycle is the last DRAIN cycle so busy drops together with done.
  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      state     <= IDLE;
      cmd_q     <= '0;
      cmd_ready <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          cmd_ready <= 1'b1;
          busy      <= 1'b0;
          done      <= 1'b0;
          if (accept_c) begin
            cmd_q     <= cmd_in_c;
            cmd_ready <= 1'b0;
            busy      <= 1'b1;
            if (zero_c) begin
              state <= DRAIN;
              done  <= 1'b1;
            end else begin
              state <= ISSUE;
            end
          end
        end
        ISSUE: begin
          if (last_c) state <= DRAIN;
        end
        DRAIN: begin
          if (done) begin
            state     <= IDLE;
            done      <= 1'b0;
            busy      <= 1'b0;
            cmd_ready <= 1'b1;
          end else if (!v1) begin
            done <= 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Stage 1 pairs coordinates with the returning source data; FB outputs register it.
  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      v1              <= 1'b0;
      dx1             <= '0;
      dy1             <= '0;
      FBwe            <= 1'b0;
      FBwrite_address <= '0;
      FBdata_In       <= '0;
    end else begin
      v1   <= issue_c;
      dx1  <= dx;
      dy1  <= dy;
      FBwe <= v1 && !clip_c && !key_c;
      if (v1) begin
        FBwrite_address <= ADDR_W'(dy1) * ADDR_W'(FB_W) + ADDR_W'(dx1);
        FBdata_In       <= cmd_q.mode ? cmd_q.fill_color : src_data;
      end
    end
  end

endmodule
